sevenseg_mux_driver: RTL
========================

Name: sevenseg_mux_driver

Overview:
Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits sharing one segment bus. Generalises the single-digit hex decoder to N digits: a refresh counter scans digits, a blanking interval suppresses ghosting, and a frame-coherent shadow register samples the packed hex inputs. Sits between switch/logic sources and the board display pins.

Parameters:
NUM_DIGITS, 2, number of digits scanned (1..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 500, cycles at slot start with all anodes off (1 <= BLANK_CYCLES < REFRESH_DIV)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
digits_in  input  4*NUM_DIGITS  packed hex nibbles; digit i = digits_in[4i+3:4i], digit 0 least significant
freeze  input  1  1 = inhibit shadow reload; display holds last captured value
seg  output  7  segment drive, active-low, seg[0]=a ... seg[6]=g
an  output  NUM_DIGITS  anode enables, active-low, an[i] drives digit i
frame  output  1  one-cycle pulse the cycle after each shadow-capture opportunity

Behaviour:
- Clock is clk; reset is synchronous, active-low. While reset=0 at an edge: cnt=0, ptr=0, shadow=0, seg=7'b1111111, an=all 1s, frame=0.
- State: cnt (0..REFRESH_DIV-1), ptr (0..NUM_DIGITS-1), shadow (4*NUM_DIGITS bits).
- Each edge with reset=1: cnt increments; at REFRESH_DIV-1 it wraps to 0 and ptr advances, wrapping NUM_DIGITS-1 -> 0.
- Capture: on an edge where cnt==0 and ptr==0 (frame start), shadow <= digits_in unless freeze=1. frame <= 1 on that edge regardless of freeze, else 0.
- Outputs registered, 1-cycle latency from (cnt, ptr): if cnt < BLANK_CYCLES, an <= all 1s and seg <= 7'b1111111; else an <= all 1s except bit ptr = 0, and seg <= decode(shadow digit ptr).
- seg and an always update on the same edge; at most one an bit is ever low.
- Decode (gfedcba, active-low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
- digits_in changes mid-frame are not visible until the next frame start; no partial-frame tearing.
- First frame after reset: capture occurs on the first edge with reset=1.
- Reset mid-slot: next cycle all off; scanning restarts at digit 0 with a full blank interval.
- NUM_DIGITS=1: ptr is constant 0; frame pulses once per slot.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles exactly.

Optional Feature:
SEVENSEG_LEADING_ZERO_BLANK_EN defined: any digit above the most-significant nonzero shadow digit is suppressed during its slot (an all 1s, seg 7'b1111111); digit 0 is always shown; blanking is evaluated on shadow, not on digits_in. Undefined: every digit always displayed, including leading zeros.

Test Plan:
(Sim params NUM_DIGITS=2, REFRESH_DIV=8, BLANK_CYCLES=2.)
1. reset=0 for 3 edges -> an=2'b11, seg=7'b1111111, frame=0 every cycle.
2. digits_in=8'h4A, release reset -> frame=1 one cycle after first edge; 2 blank cycles, then an=2'b10, seg=0001000 for 6 cycles; 2 blank; an=2'b01, seg=0011001 for 6 cycles; frame recurs every 16 cycles.
3. Change digits_in 8'h4A -> 8'h99 at cycle 5 -> current frame still shows A/4; from next frame both digits seg=0010000.
4. freeze=1, digits_in=8'hE3 -> display keeps previous value, frame still pulses; freeze=0 -> next frame shows 3=0110000 and E=0000110.
5. reset=0 for one edge during digit 1 lit window -> next cycle an=2'b11; scan restarts at digit 0 after 2 blank cycles; then sweep all 16 nibbles on digit 0 and check each decode code.
6. digits_in=8'h05 -> macro defined: digit 1 slot has an=2'b11 throughout, digit 0 seg=0010010; macro undefined: digit 1 shows seg=1000000.

Source files
------------

// File: rtl/sevenseg_mux_driver.sv
`default_nettype none
// ============================================================================
// sevenseg_mux_driver: time-multiplexed common-anode 7-seg driver with a
// frame-coherent shadow register. Optional macro: SEVENSEG_LEADING_ZERO_BLANK_EN
// Revision: 1.0
// ============================================================================
module sevenseg_mux_driver #(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    freeze,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [PTR_W-1:0]        ptr;
  logic [4*NUM_DIGITS-1:0] shadow;

  logic [3:0]              sel_nib;
  logic                    digit_on;
  logic                    frame_start;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  // Active-low gfedcba patterns
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  assign frame_start = (cnt == '0) && (ptr == '0);

  always_comb begin
    sel_nib  = 4'h0;
    digit_on = 1'b1;
    an_next  = '1;
    seg_next = 7'b1111111;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ptr == PTR_W'(i)) sel_nib = shadow[4*i +: 4];
    end
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    begin : lzb
      // Walk down from the top digit; a digit is shown once any digit at or
      // above it is nonzero. Digit 0 is always shown.
      logic higher_nz;
      higher_nz = 1'b0;
      digit_on  = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
        higher_nz = higher_nz | (shadow[4*i +: 4] != 4'h0);
        if (ptr == PTR_W'(i)) digit_on = higher_nz || (i == 0);
      end
    end
`endif
    if ((cnt >= BLANK_END) && digit_on) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (ptr == PTR_W'(i)) an_next[i] = 1'b0;
      end
      seg_next = decode(sel_nib);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      ptr    <= '0;
      shadow <= '0;
      seg    <= 7'b1111111;
      an     <= '1;
      frame  <= 1'b0;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        ptr <= (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (frame_start && !freeze) shadow <= digits_in;
      frame <= frame_start;
      seg   <= seg_next;
      an    <= an_next;
    end
  end

endmodule
`default_nettype wire
